// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Receives the 5-byte OLED link frame 0x00, D[7:0], D[15:8], D[23:16], 0x07
//   over an 8N1 LSB-first serial line and presents the 24-bit payload with a
//   one-cycle valid strobe.
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   rs232_rx   serial line, idles high, asynchronous to clk
//   rx_data    payload of the last good frame (byte1 -> [7:0] ... byte3 -> [23:16])
//   rx_valid   one-cycle pulse, rx_data updated on the same cycle
//   frame_err  one-cycle pulse: bad tail, bad stop bit inside a frame, or timeout
//   busy       frame parser is outside IDLE
`timescale 1ns/1ps
module uart_frame_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rs232_rx,
    output logic [23:0] rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int CPB       = CLK_FREQ / BAUD;
    localparam int HALF      = CPB / 2;
    localparam int BCW       = $clog2(CPB + 1);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CPB;
    localparam int TCW       = $clog2(TMO_LIMIT + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;
    typedef enum logic [2:0] {IDLE, B0, B1, B2, TAIL} pstate_t;

    logic           rx_meta, rx_sync, rx_prev;
    rstate_t        r_state, r_state_nxt;
    logic [BCW-1:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]     bit_idx, bit_idx_nxt;
    logic           shift_en;
    logic [7:0]     shift_p0;
    logic           ok_nxt, bad_nxt;
    logic           byte_ok_p0, byte_bad_p0;
    logic           byte_ok_p1, byte_bad_p1;
    logic [7:0]     byte_p1;

    pstate_t        p_state, p_state_nxt;
    logic           valid_nxt, err_nxt, tmo_clr, tmo_hit;
    logic           ld0, ld1, ld2;
    logic [TCW-1:0] tmo_cnt;
    logic [7:0]     sh0, sh1, sh2;

    // ---- stage p0: synchroniser and byte receiver ----
    always_comb begin
        r_state_nxt = r_state;
        bit_cnt_nxt = bit_cnt + 1'b1;
        bit_idx_nxt = bit_idx;
        shift_en    = 1'b0;
        ok_nxt      = 1'b0;
        bad_nxt     = 1'b0;
        case (r_state)
            R_IDLE: begin
                bit_cnt_nxt = '0;
                if (rx_prev && !rx_sync) r_state_nxt = R_START;
            end
            R_START: begin
                // Mid-start sample; a line already back high was a glitch.
                if (bit_cnt == BCW'(HALF - 1)) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    r_state_nxt = rx_sync ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (bit_cnt == BCW'(CPB - 1)) begin
                    bit_cnt_nxt = '0;
                    shift_en    = 1'b1;
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) r_state_nxt = R_STOP;
                end
            end
            R_STOP: begin
                if (bit_cnt == BCW'(CPB - 1)) begin
                    bit_cnt_nxt = '0;
                    ok_nxt      = rx_sync;
                    bad_nxt     = !rx_sync;
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            r_state     <= R_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            byte_ok_p0  <= 1'b0;
            byte_bad_p0 <= 1'b0;
            byte_ok_p1  <= 1'b0;
            byte_bad_p1 <= 1'b0;
        end else begin
            rx_meta     <= rs232_rx;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            r_state     <= r_state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            byte_ok_p0  <= ok_nxt;
            byte_bad_p0 <= bad_nxt;
            byte_ok_p1  <= byte_ok_p0;
            byte_bad_p1 <= byte_bad_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) shift_p0 <= {rx_sync, shift_p0[7:1]};
        byte_p1 <= shift_p0;
    end

    // ---- stage p1: frame parser and timeout ----
    assign tmo_hit = (tmo_cnt == TCW'(TMO_LIMIT - 1));
    assign busy    = (p_state != IDLE);

    always_comb begin
        p_state_nxt = p_state;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        tmo_clr     = 1'b0;
        ld0         = 1'b0;
        ld1         = 1'b0;
        ld2         = 1'b0;
        if (p_state == IDLE) begin
            if (byte_ok_p1 && byte_p1 == 8'h00) begin
                p_state_nxt = B0;
                tmo_clr     = 1'b1;
            end
        end else if (byte_ok_p1) begin
            // A byte event on the timeout cycle takes priority.
            case (p_state)
                B0:      begin ld0 = 1'b1; p_state_nxt = B1; end
                B1:      begin ld1 = 1'b1; p_state_nxt = B2; end
                B2:      begin ld2 = 1'b1; p_state_nxt = TAIL; end
                default: begin
                    valid_nxt   = (byte_p1 == 8'h07);
                    err_nxt     = (byte_p1 != 8'h07);
                    p_state_nxt = IDLE;
                end
            endcase
        end else if (byte_bad_p1 || tmo_hit) begin
            err_nxt     = 1'b1;
            p_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_state   <= IDLE;
            tmo_cnt   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_data   <= '0;
        end else begin
            p_state   <= p_state_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= err_nxt;
            if (tmo_clr || byte_ok_p1 || byte_bad_p1) tmo_cnt <= '0;
            else if (busy)                           tmo_cnt <= tmo_cnt + 1'b1;
            if (valid_nxt) rx_data <= {sh2, sh1, sh0};
        end
    end

    always_ff @(posedge clk) begin
        if (ld0) sh0 <= byte_p1;
        if (ld1) sh1 <= byte_p1;
        if (ld2) sh2 <= byte_p1;
    end

endmodule
